// File: rtl/cp0_exc_sequencer.sv
// -----------------------------------------------------------------------------
// cp0_exc_sequencer
//
// Exception / ERET sequencer on the initiator side of the CP0 register block.
// It watches the MEM-stage exception flags and the CP0 Status/Cause/EPC values
// and picks the highest-priority event: interrupt, RI, Ov, Tr, Sys, then ERET.
// The sequencer then drives the single CP0 write port over several cycles,
// pulses the Cause side-band fields, and stalls, flushes and redirects the
// pipeline.
//
//   exception : IDLE -> WR_EPC -> WR_STATUS -> REDIRECT -> IDLE  (flush at N+3)
//   ERET      : IDLE -> ER_STATUS -> REDIRECT -> IDLE            (flush at N+2)
//
// Build option:
//   CP0_DSLOT_BD_EN  when defined, an instruction in a delay slot saves
//                    EPC = pc - 4 and sets BD. When undefined, mem_in_dslot_i
//                    is ignored, so EPC = pc and BD = 0.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   status_i/cause_i/epc_i  current CP0 register values
//   mem_valid_i           MEM stage holds a valid instruction
//   mem_pc_i              MEM instruction address
//   mem_in_dslot_i        MEM instruction sits in a branch delay slot
//   exc_*_i               RI / Ov / Tr / Sys / ERET flags from MEM
//   cp0_we_o/waddr_o/wdata_o  CP0 write port (addr/data are 0 when we=0)
//   exc_valid_o           one-cycle pulse; CP0 loads Cause.ExcCode and Cause.BD
//   exccode_o, bd_o       Cause fields that go with exc_valid_o
//   stall_o               hold the pipeline while a sequence runs
//   flush_o, new_pc_o     one-cycle flush and the redirect target
// All outputs are registered.
// -----------------------------------------------------------------------------
module cp0_exc_sequencer #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter logic [4:0]  REG_EPC    = 5'd14,
   parameter logic [4:0]  REG_STATUS = 5'd12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_dslot_i,
   input  logic        exc_ri_i,
   input  logic        exc_ov_i,
   input  logic        exc_tr_i,
   input  logic        exc_sys_i,
   input  logic        exc_eret_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_wdata_o,
   output logic        exc_valid_o,
   output logic [4:0]  exccode_o,
   output logic        bd_o,
   output logic        stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_EPC,
      S_WR_STATUS,
      S_ER_STATUS,
      S_REDIRECT
   } state_t;

   localparam logic [4:0]  CODE_INT = 5'h00;
   localparam logic [4:0]  CODE_SYS = 5'h08;
   localparam logic [4:0]  CODE_RI  = 5'h0A;
   localparam logic [4:0]  CODE_OV  = 5'h0C;
   localparam logic [4:0]  CODE_TR  = 5'h0D;
   localparam logic [31:0] EXL_MASK = 32'h0000_0002;

   state_t      state_q;
   logic [4:0]  code_q;
   logic        bd_q;

   logic        we_q;
   logic [4:0]  waddr_q;
   logic [31:0] wdata_q;
   logic        exc_valid_q;
   logic [4:0]  exccode_q;
   logic        bd_out_q;
   logic        stall_q;
   logic        flush_q;
   logic [31:0] new_pc_q;

   logic        irq_pend_d;
   logic        exc_any_d;
   logic [4:0]  code_d;
   logic [31:0] epc_lat_d;
   logic        bd_d;
   logic        unused_bits;

   // Interrupts are taken only with IE=1, EXL=0 and a pending line that is unmasked.
   assign irq_pend_d = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

   // Priority select; ERET is handled separately and loses to any exception.
   always_comb begin
      exc_any_d = 1'b1;
      code_d    = CODE_INT;
      if (irq_pend_d)     code_d = CODE_INT;
      else if (exc_ri_i)  code_d = CODE_RI;
      else if (exc_ov_i)  code_d = CODE_OV;
      else if (exc_tr_i)  code_d = CODE_TR;
      else if (exc_sys_i) code_d = CODE_SYS;
      else                exc_any_d = 1'b0;
   end

`ifdef CP0_DSLOT_BD_EN
   // A delay-slot instruction restarts at its branch, one word earlier.
   assign epc_lat_d   = mem_in_dslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
   assign bd_d        = mem_in_dslot_i;
   assign unused_bits = ^{cause_i[31:16], cause_i[7:0]};
`else
   assign epc_lat_d   = mem_pc_i;
   assign bd_d        = 1'b0;
   assign unused_bits = ^{cause_i[31:16], cause_i[7:0], mem_in_dslot_i};
`endif

   // Outputs are registered together with the state transition, so each
   // state's outputs are visible during the cycle spent in that state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         code_q      <= 5'd0;
         bd_q        <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= 5'd0;
         wdata_q     <= 32'd0;
         exc_valid_q <= 1'b0;
         exccode_q   <= 5'd0;
         bd_out_q    <= 1'b0;
         stall_q     <= 1'b0;
         flush_q     <= 1'b0;
         new_pc_q    <= 32'd0;
      end else begin
         we_q        <= 1'b0;
         waddr_q     <= 5'd0;
         wdata_q     <= 32'd0;
         exc_valid_q <= 1'b0;
         exccode_q   <= 5'd0;
         bd_out_q    <= 1'b0;
         stall_q     <= 1'b0;
         flush_q     <= 1'b0;
         new_pc_q    <= 32'd0;
         case (state_q)
            S_IDLE: begin
               if (mem_valid_i && exc_any_d) begin
                  code_q  <= code_d;
                  bd_q    <= bd_d;
                  state_q <= S_WR_EPC;
                  we_q    <= 1'b1;
                  waddr_q <= REG_EPC;
                  wdata_q <= epc_lat_d;
                  stall_q <= 1'b1;
               end else if (mem_valid_i && exc_eret_i) begin
                  state_q <= S_ER_STATUS;
                  we_q    <= 1'b1;
                  waddr_q <= REG_STATUS;
                  wdata_q <= status_i & ~EXL_MASK;
                  stall_q <= 1'b1;
               end
            end
            S_WR_EPC: begin
               state_q     <= S_WR_STATUS;
               we_q        <= 1'b1;
               waddr_q     <= REG_STATUS;
               wdata_q     <= status_i | EXL_MASK;
               exc_valid_q <= 1'b1;
               exccode_q   <= code_q;
               bd_out_q    <= bd_q;
               stall_q     <= 1'b1;
            end
            S_WR_STATUS: begin
               state_q  <= S_REDIRECT;
               flush_q  <= 1'b1;
               stall_q  <= 1'b1;
               new_pc_q <= EXC_VECTOR;
            end
            S_ER_STATUS: begin
               // EPC is captured here as the ERET return target.
               state_q  <= S_REDIRECT;
               flush_q  <= 1'b1;
               stall_q  <= 1'b1;
               new_pc_q <= epc_i;
            end
            S_REDIRECT: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cp0_we_o    = we_q;
   assign cp0_waddr_o = waddr_q;
   assign cp0_wdata_o = wdata_q;
   assign exc_valid_o = exc_valid_q;
   assign exccode_o   = exccode_q;
   assign bd_o        = bd_out_q;
   assign stall_o     = stall_q;
   assign flush_o     = flush_q;
   assign new_pc_o    = new_pc_q;

endmodule

// File: doc/cp0_exc_sequencer.md
Name: cp0_exc_sequencer

Overview:
- Exception/ERET sequencer on the initiator side of the CP0 register block.
- Consumes CP0 Status/Cause/EPC outputs and MEM-stage exception flags, and selects the highest-priority event.
- Drives the CP0 single write port (EPC, Status.EXL) as a multi-cycle sequence, pulses Cause side-band fields, and stalls, flushes and redirects the pipeline.
- Sits beside the pipeline ctrl block, fed from the MEM stage.

Parameters:
- EXC_VECTOR, 32'h00000020, exception entry PC.
- REG_EPC, 5'd14, CP0 EPC register address.
- REG_STATUS, 5'd12, CP0 Status register address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- status_i  in  32  CP0 Status value.
- cause_i  in  32  CP0 Cause value.
- epc_i  in  32  CP0 EPC value.
- mem_valid_i  in  1  MEM stage holds a valid instruction.
- mem_pc_i  in  32  MEM instruction address.
- mem_in_dslot_i  in  1  MEM instruction is in a branch delay slot.
- exc_ri_i  in  1  reserved instruction.
- exc_ov_i  in  1  overflow.
- exc_tr_i  in  1  trap.
- exc_sys_i  in  1  syscall.
- exc_eret_i  in  1  eret.
- cp0_we_o  out  1  CP0 write enable.
- cp0_waddr_o  out  5  CP0 write address.
- cp0_wdata_o  out  32  CP0 write data.
- exc_valid_o  out  1  one-cycle pulse; CP0 loads Cause.ExcCode and Cause.BD.
- exccode_o  out  5  ExcCode for Cause[6:2].
- bd_o  out  1  BD for Cause[31].
- stall_o  out  1  hold the pipeline.
- flush_o  out  1  one-cycle pipeline flush.
- new_pc_o  out  32  redirect PC, valid while flush_o=1.

Behaviour:
- All outputs are registered. Reset values: every output 0, FSM in IDLE.
- Interrupt pending = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
- Detection happens only in IDLE with mem_valid_i=1.
- Priority and ExcCode:
  - interrupt: 0x00
  - RI: 0x0A
  - Ov: 0x0C
  - Tr: 0x0D
  - Sys: 0x08
  - ERET: no code
- On detect, latch the code and epc_lat, then go to WR_EPC (exception) or ER_STATUS (ERET).
- BD handling (see Optional Feature for the delay-slot case):
  - mem_in_dslot_i=0: epc_lat = mem_pc_i, bd=0.
  - mem_in_dslot_i=1 with feature absent: epc_lat = mem_pc_i, bd=0.
- States:
  - IDLE: stall_o=0, no writes.
  - WR_EPC: we=1, waddr=REG_EPC, wdata=epc_lat, stall_o=1. Next WR_STATUS.
  - WR_STATUS: we=1, waddr=REG_STATUS, wdata=status_i|32'h2 (EXL set), exc_valid_o=1 with latched exccode/bd, stall_o=1. Next REDIRECT.
  - ER_STATUS: we=1, waddr=REG_STATUS, wdata=status_i&~32'h2 (EXL clear), stall_o=1. Latch epc_i into the target. Next REDIRECT.
  - REDIRECT: flush_o=1, stall_o=1, new_pc_o = EXC_VECTOR (exception) or the latched EPC (ERET). Next IDLE.
- Latency:
  - Exception: detect at cycle N, flush at N+3.
  - ERET: detect at cycle N, flush at N+2.
- Flags arriving while not in IDLE are ignored; the pipeline is stalled, so they re-present later.
- Several flags asserted together: only the highest-priority one is taken.
- ERET combined with any exception flag: the exception wins.
- Reset mid-sequence: return to IDLE next cycle, all outputs 0; a remaining write is never issued.
- cp0_we_o is never high for two addresses in the same cycle. waddr/wdata are 0 when we=0.

Optional Feature:
- Macro: CP0_DSLOT_BD_EN.
- Defined: mem_in_dslot_i=1 gives epc_lat = mem_pc_i - 4 (32-bit wrap-around) and bd=1.
- Undefined: mem_in_dslot_i is ignored; epc_lat = mem_pc_i, bd=0.

Test Plan:
- Syscall: status=0x10000001, mem_pc=0x00000100, exc_sys=1.
  - N+1: we, addr 14, data 0x100.
  - N+2: we, addr 12, data 0x10000003; exc_valid=1, exccode=0x08.
  - N+3: flush=1, new_pc=0x20.
- Interrupt: status=0x10000401, cause[10]=1.
  - Exception taken with exccode=0x00.
  - Same stimulus with status[1]=1 (EXL): no action, stall stays 0.
- ERET: status=0x10000003, epc=0x00000200.
  - N+1: we, addr 12, data 0x10000001.
  - N+2: flush=1, new_pc=0x200.
- Priority: exc_ri, exc_ov and exc_sys asserted together -> exccode=0x0A only, a single sequence.
- Reset asserted in WR_EPC -> next cycle all outputs 0, no Status write follows.
- Delay slot with the macro defined: mem_pc=0x00000000, dslot=1 -> EPC written 0xFFFFFFFC, bd=1.
  - Macro undefined: EPC written 0x0, bd=0.
